// File: rtl/vscale_mul_div_pkg.sv
`default_nettype none
// vscale_mul_div_pkg: funct3 op encodings, FSM states and operand-sign helpers.
// Revision: 1.0
package vscale_mul_div_pkg;

  localparam int MD_OP_WIDTH = 3;

  typedef enum logic [MD_OP_WIDTH-1:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_STATE_IDLE    = 2'd0,
    MD_STATE_COMPUTE = 2'd1,
    MD_STATE_DONE    = 2'd2
  } md_state_e;

  function automatic logic in1_signed(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) || (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

  function automatic logic in2_signed(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vscale_mul_div_negate.sv
`default_nettype none
// vscale_mul_div_negate: conditional two's-complement of a W-bit value.
// Revision: 1.0
module vscale_mul_div_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = neg ? -a : a;

endmodule
`default_nettype wire

// File: rtl/vscale_mul_div.sv
`default_nettype none
// vscale_mul_div: iterative RV32M/RV64M multiply/divide, one bit per cycle, fixed XLEN+1 latency.
// Revision: 1.0
module vscale_mul_div
  import vscale_mul_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [MD_OP_WIDTH-1:0] req_op,
  input  logic [XLEN-1:0]        req_in1,
  input  logic [XLEN-1:0]        req_in2,
  input  logic                   kill,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [XLEN-1:0]        resp_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  md_state_e               state_q, state_d;
  logic [MD_OP_WIDTH-1:0]  op_q;
  logic                    neg_q;
  logic [CW-1:0]           cnt_q;
  logic [XLEN-1:0]         opd_q, result_q, result_d;
  logic [2*XLEN-1:0]       acc_q, acc_d, prod;

  logic                    accept, s1, s2, neg_d, is_div, last;
  logic [XLEN-1:0]         abs1, abs2, hi, lo, quo_rem, div_res;
  logic [XLEN:0]           add_a, add_b, sum;

  assign req_ready   = (state_q == MD_STATE_IDLE) && !kill;
  assign accept      = req_valid && req_ready;
  assign resp_valid  = (state_q == MD_STATE_DONE);
  assign resp_result = result_q;

  assign s1 = in1_signed(req_op) && req_in1[XLEN-1];
  assign s2 = in2_signed(req_op) && req_in2[XLEN-1];
  // Remainder follows the dividend sign; a zero divisor leaves the all-ones quotient uncorrected.
  assign neg_d = !req_op[2] ? (s1 ^ s2) :
                 req_op[1]  ? s1 : ((s1 ^ s2) && (req_in2 != '0));

  vscale_mul_div_negate #(.W(XLEN)) u_abs1 (.neg(s1), .a(req_in1), .y(abs1));
  vscale_mul_div_negate #(.W(XLEN)) u_abs2 (.neg(s2), .a(req_in2), .y(abs2));

  assign is_div = op_q[2];
  assign last   = (cnt_q == LAST);
  assign hi     = acc_q[2*XLEN-1:XLEN];
  assign lo     = acc_q[XLEN-1:0];

  // Shared adder: multiply adds the multiplicand to the high half, divide subtracts the divisor
  // from the shifted partial remainder.
  always_comb begin
    add_a = is_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
    add_b = {1'b0, opd_q} ^ {(XLEN+1){is_div}};
    sum   = add_a + add_b + (XLEN+1)'(is_div);
    acc_d = acc_q;
    if (is_div)
      acc_d = sum[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0} : {sum[XLEN-1:0], lo[XLEN-2:0], 1'b1};
    else
      acc_d = lo[0] ? {sum, lo[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
  end

  assign quo_rem = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];

  vscale_mul_div_negate #(.W(2*XLEN)) u_prod (.neg(neg_q), .a(acc_d),   .y(prod));
  vscale_mul_div_negate #(.W(XLEN))   u_div  (.neg(neg_q), .a(quo_rem), .y(div_res));

  assign result_d = is_div                ? div_res :
                    (op_q == MD_OP_MUL)   ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= MD_STATE_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = MD_STATE_IDLE;
    end else begin
      case (state_q)
        MD_STATE_IDLE:    if (req_valid) state_d = MD_STATE_COMPUTE;
        MD_STATE_COMPUTE: if (last)      state_d = MD_STATE_DONE;
        MD_STATE_DONE:    if (resp_ready) state_d = MD_STATE_IDLE;
        default:          state_d = MD_STATE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= req_op;
      neg_q <= neg_d;
      opd_q <= abs2;
      acc_q <= {{XLEN{1'b0}}, abs1};
      cnt_q <= '0;
    end else if ((state_q == MD_STATE_COMPUTE) && !kill) begin
      acc_q <= acc_d;
      if (last) result_q <= result_d;
      else      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vscale_mul_div.sv
`default_nettype none
// tb_vscale_mul_div: table-driven vectors with an expected-result queue, plus kill/backpressure/reset sequences.
// Revision: 1.0
module tb_vscale_mul_div;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_op = 3'd0;
  logic [XLEN-1:0] req_in1 = '0;
  logic [XLEN-1:0] req_in2 = '0;
  logic            kill = 1'b0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_result;

  vscale_mul_div #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_in1(req_in1), .req_in2(req_in2), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    string           name;
  } vec_t;

  vec_t            vecs[$];
  logic [XLEN-1:0] exp_q[$];
  int              checks = 0;
  int              passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drives one request at a negedge and returns just after the accepting edge.
  task automatic issue(input string name, input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    check({name, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_in1   = a;
    req_in2   = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for the response, checks latency and value, holds resp_ready low for 'hold' DONE cycles.
  task automatic wait_resp(input string name, input int hold);
    int n = 0;
    logic [XLEN-1:0] exp;
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'd33);
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL %s_scoreboard: got response with no expected entry, required one entry", name);
      exp = 'x;
    end else begin
      exp = exp_q.pop_front();
    end
    check({name, "_result"}, 64'(resp_result), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      check({name, "_hold"}, {31'd0, resp_valid, resp_result}, {31'd0, 1'b1, exp});
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check({name, "_after_handshake"}, {62'd0, resp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int hold);
    issue(name, op, a, b);
    exp_q.push_back(exp);
    wait_resp(name, hold);
  endtask

  task automatic expect_no_resp(input string name, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min"});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones"});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones"});
    vecs.push_back('{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, "mul_shift"});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, "mulh_m1_1"});
    vecs.push_back('{3'd3, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, "mulhu_carry"});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2"});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2"});
    vecs.push_back('{3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, "divu_7_2"});
    vecs.push_back('{3'd7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, "remu_7_2"});
    vecs.push_back('{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2"});
    vecs.push_back('{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, "rem_7_m2"});
    vecs.push_back('{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "div_by_zero"});
    vecs.push_back('{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "rem_by_zero"});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, "rem_neg_by_zero"});
    vecs.push_back('{3'd5, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, "divu_by_zero"});
    vecs.push_back('{3'd7, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, "remu_by_zero"});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow"});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_overflow"});
    vecs.push_back('{3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, "divu_big"});
    vecs.push_back('{3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, "remu_big"});

    // Reset state
    #3;
    check("reset_outputs", {61'd0, req_ready, resp_valid, 1'b0}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("reset_result", 64'(resp_result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

    // Backpressure: five DONE cycles with resp_ready low, consumed on the sixth
    do_op("backpressure", 3'd0, 32'h0000_0009, 32'h0000_000B, 32'h0000_0063, 5);

    // Kill mid-COMPUTE: no response, unit idle again
    issue("kill_op", 3'd0, 32'h0000_0005, 32'h0000_0006);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill_idle", {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
    expect_no_resp("kill_no_resp", 40);

    // Kill held in IDLE blocks acceptance
    @(negedge clk);
    kill      = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_in1   = 32'h0000_0002;
    req_in2   = 32'h0000_0002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("kill_blocks_ready", 64'(req_ready), 64'd0);
    end
    kill      = 1'b0;
    req_valid = 1'b0;
    #1 check("kill_release_ready", 64'(req_ready), 64'd1);
    expect_no_resp("kill_idle_no_resp", 40);
    do_op("mul_after_kill", 3'd0, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C, 0);

    // Asynchronous reset mid-COMPUTE clears the held previous result
    issue("reset_compute_op", 3'd5, 32'h0000_0064, 32'h0000_0007);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("reset_compute_valid", {62'd0, resp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
    check("reset_compute_result", 64'(resp_result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    expect_no_resp("reset_compute_no_resp", 40);

    // Asynchronous reset while holding a result in DONE
    issue("reset_done_op", 3'd0, 32'h0000_0011, 32'h0000_0003);
    begin
      int n = 0;
      while (!resp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("reset_done_reached", {31'd0, resp_valid, resp_result}, {31'd0, 1'b1, 32'h0000_0033});
    end
    #2 reset_n = 1'b0;
    #1;
    check("reset_done_cleared", {31'd0, resp_valid, resp_result}, {31'd0, 1'b0, 32'h0});
    @(negedge clk);
    reset_n = 1'b1;
    do_op("mulhu_after_reset", 3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vscale_mul_div.md
# vscale_mul_div

Iterative, parametrised multiply/divide unit for the RV32M/RV64M extension. It sits beside the ALU in the execute stage and takes operands through a valid/ready request handshake. It computes the result over XLEN cycles using radix-2 shift-add for multiply and restoring division for divide, and returns it through a valid/ready response handshake. A `kill` input lets a pipeline flush abort an in-flight operation.

## Interface
- `XLEN`, 32, operand/result width; must be even and ≥ 8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; equals (state == IDLE) && !kill.
- `req_op`  in  3  RISC-V funct3 encoding: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- `req_in1`  in  XLEN  rs1 operand (multiplicand/dividend).
- `req_in2`  in  XLEN  rs2 operand (multiplier/divisor).
- `kill`  in  1  synchronous abort of any accepted, unreturned operation.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes result.
- `resp_result`  out  XLEN  result.

## Operation
- States:
  - IDLE: waiting for a request.
  - COMPUTE: XLEN iterations.
  - DONE: holding the result.
- IDLE→COMPUTE on `req_valid && req_ready`. The unit latches the op, the operand magnitudes, and the negate-result flag, and sets counter = 0.
- Operand sign handling:
  - in1 is treated as signed for MULH, MULHSU, DIV and REM.
  - in2 is treated as signed for MULH, DIV and REM.
  - Signed operands are converted to magnitude at accept.
- Multiply:
  - A 2·XLEN accumulator adds the shifted multiplicand when the current multiplier bit is 1. One bit is processed per cycle.
  - At finish, the 2·XLEN product is negated if the signs differ.
  - MUL selects the low XLEN bits; MULH, MULHSU and MULHU select the high XLEN bits.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle. Each cycle the remainder shifts left by 1 and brings in the next dividend bit; if it is ≥ the divisor, the divisor is subtracted and the quotient bit is 1.
  - The quotient is negated if the signs differ; the remainder takes the sign of the dividend.
  - DIV and DIVU select the quotient; REM and REMU select the remainder.
- Divide by zero:
  - Quotient = all ones; remainder = in1, unmodified.
  - Sign correction is suppressed in this case.
- Signed overflow (in1 = −2^(XLEN−1), in2 = −1): quotient = in1, remainder = 0.
- COMPUTE→DONE when counter == XLEN−1, after the final iteration. The result is sign-corrected and registered into `resp_result` on that edge.
- DONE→IDLE on `resp_ready`.
- `kill` (any state) → IDLE on the next edge. No response is produced, and an in-progress result is discarded. In IDLE, `kill` blocks acceptance of a request in the same cycle.
- Reset forces IDLE with all datapath registers zero. This holds at any point, including mid-COMPUTE.

## Timing
- Reset values: `req_ready` = 1 (when `kill` = 0), `resp_valid` = 0, `resp_result` = 0.
- Accept at edge T0. COMPUTE spans cycles T0+1 … T0+XLEN. `resp_valid` rises in cycle T0+XLEN+1.
- Latency from accept to `resp_valid` is XLEN+1 cycles, fixed for every op, including divide by zero and overflow. There is no early-out.
- `resp_valid` and `resp_result` are registered and remain stable until the `resp_ready` handshake.
- `req_ready` = 0 in COMPUTE and DONE, so there is no back-to-back accept in the handshake cycle. Minimum issue interval is XLEN+2 cycles.
- Simultaneous `kill` and `resp_ready` in DONE: kill wins; this is identical to the handshake (→ IDLE), so the result counts as consumed or discarded by the consumer's own choice.
- Counter is $clog2(XLEN) bits and does not wrap beyond XLEN−1.

## Structure
- Shared header `vscale_md_constants.vh` holds:
  - the MD_OP_* funct3 encodings and MD_OP_WIDTH = 3;
  - the state encodings MD_STATE_IDLE / COMPUTE / DONE.
- Single module. The datapath is one 2·XLEN shifter/accumulator shared by multiply and divide, plus one XLEN+1-bit subtractor/adder.
- Optional leaf `vscale_md_negate`: a conditional two's-complement helper of width W, instantiated for operand abs and result correction.

## Test plan
- XLEN = 32. MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - Each result asserts `resp_valid` exactly 33 cycles after accept.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU 7 / 2 → 3; REMU → 1.
- Divide by zero:
  - DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
  - DIVU 0x80000000 / 0 → 0xFFFFFFFF; REMU → 0x80000000.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Kill 10 cycles after accept:
  - `resp_valid` never asserts and `req_ready` = 1 on the next cycle.
  - A following MUL 3 × 4 returns 12.
  - `kill` held high with `req_valid` in IDLE is never accepted.
- Backpressure: `resp_ready` low for 5 cycles in DONE keeps `resp_result` stable, and it is consumed on cycle 6.
  - Dropping `reset_n` mid-COMPUTE clears `resp_valid` and `resp_result` to 0 asynchronously, before the next edge.
